// File: rtl/parking_gate_ctrl_if.sv
// Entrance-gate bus: car sensors, keypad strobe/code and the gate status outputs.
//   master : environment side (drives sensors/keypad, observes lights and status)
//   slave  : controller side (observes sensors/keypad, drives lights and status)
interface parking_gate_ctrl_if;
  logic       sensor_entrance;
  logic       sensor_gate;
  logic       car_leave;
  logic       pass_valid;
  logic [7:0] pass_code;
  logic       red;
  logic       green;
  logic       gate_open;
  logic       lockout;
  logic       full;
  logic [3:0] occupancy;
  logic [1:0] wrong_cnt;

  modport master (
    output sensor_entrance, sensor_gate, car_leave, pass_valid, pass_code,
    input  red, green, gate_open, lockout, full, occupancy, wrong_cnt
  );

  modport slave (
    input  sensor_entrance, sensor_gate, car_leave, pass_valid, pass_code,
    output red, green, gate_open, lockout, full, occupancy, wrong_cnt
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Parking entrance-gate controller: detects an arriving car, checks the keypad
// code, opens the barrier, tracks lot occupancy and drives the entrance lights.
// Ports:
//   clk     : system clock, rising edge
//   reset   : synchronous active-high reset
//   gate_if : slave side of parking_gate_ctrl_if (sensors, keypad, lights, status)
// All outputs are registers; red feeds a penalty timer and must be glitch-free.
module parking_gate_ctrl #(
  parameter logic [7:0]  PASSWORD     = 8'hA5,
  parameter int unsigned CAPACITY     = 8,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned LOCK_CYCLES  = 10,
  parameter int unsigned WAIT_TIMEOUT = 20
) (
  input logic                 clk,
  input logic                 reset,
  parking_gate_ctrl_if.slave  gate_if
);

  localparam int unsigned OCC_W  = 4;
  localparam int unsigned WCNT_W = 2;
  localparam int unsigned WAIT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_PASS  = 3'd1;
  localparam logic [2:0] S_WRONG_PASS = 3'd2;
  localparam logic [2:0] S_RIGHT_PASS = 3'd3;
  localparam logic [2:0] S_TAILGATE   = 3'd4;
  localparam logic [2:0] S_LOCKOUT    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [WCNT_W-1:0] wrong_cnt_q, wrong_cnt_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              full_q, full_d;
  logic              gate_q;
  logic              red_q, red_d;
  logic              green_q, green_d;
  logic              gate_open_q, gate_open_d;
  logic              lockout_q, lockout_d;

  logic              code_ok;
  logic              gate_evt;
  logic              wait_expired;
  logic              wait_exit;
  logic              car_in;
  logic              car_out;
  logic [WCNT_W-1:0] wrong_inc;

  assign code_ok      = (gate_if.pass_code == PASSWORD);
  assign gate_evt     = gate_if.sensor_gate & ~gate_q;
  assign wait_expired = (wait_cnt_q == WAIT_W'(WAIT_TIMEOUT - 1));
  assign wait_exit    = ~gate_if.sensor_entrance | wait_expired;
  assign wrong_inc    = wrong_cnt_q + WCNT_W'(1);

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      wrong_cnt_q <= '0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      gate_q      <= 1'b0;
      red_q       <= 1'b0;
      green_q     <= 1'b0;
      gate_open_q <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      wrong_cnt_q <= wrong_cnt_d;
      occ_q       <= occ_d;
      full_q      <= full_d;
      gate_q      <= gate_if.sensor_gate;
      red_q       <= red_d;
      green_q     <= green_d;
      gate_open_q <= gate_open_d;
      lockout_q   <= lockout_d;
    end
  end

  // Next-state, counters, occupancy and output decode
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    wrong_cnt_d = wrong_cnt_q;
    car_in      = 1'b0;

    case (state_q)
      S_IDLE: begin
        wrong_cnt_d = '0;
        if (gate_if.sensor_entrance && !full_q) begin
          state_d    = S_WAIT_PASS;
          wait_cnt_d = '0;
        end
      end

      S_WAIT_PASS, S_WRONG_PASS: begin
        if (gate_if.pass_valid) begin
          wait_cnt_d = '0;
          if (code_ok) begin
            state_d = S_RIGHT_PASS;
          end else begin
            // First miss loads 1; later misses count up toward the limit
            wrong_cnt_d = (state_q == S_WAIT_PASS) ? WCNT_W'(1) : wrong_inc;
            if (wrong_cnt_d == WCNT_W'(MAX_TRIES)) begin
              state_d    = S_LOCKOUT;
              lock_cnt_d = '0;
            end else begin
              state_d = S_WRONG_PASS;
            end
          end
        end else if (wait_exit) begin
          state_d     = S_IDLE;
          wrong_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_RIGHT_PASS: begin
        if (gate_evt) begin
          car_in      = 1'b1;
          wrong_cnt_d = '0;
          state_d     = gate_if.sensor_entrance ? S_TAILGATE : S_IDLE;
        end
      end

      S_TAILGATE: begin
        if (gate_if.pass_valid) begin
          if (code_ok) begin
            state_d = S_RIGHT_PASS;
          end else begin
            wrong_cnt_d = WCNT_W'(1);
            wait_cnt_d  = '0;
            if (MAX_TRIES == 1) begin
              state_d    = S_LOCKOUT;
              lock_cnt_d = '0;
            end else begin
              state_d = S_WRONG_PASS;
            end
          end
        end else if (!gate_if.sensor_entrance) begin
          state_d     = S_IDLE;
          wrong_cnt_d = '0;
        end
      end

      S_LOCKOUT: begin
        if (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) begin
          state_d     = S_IDLE;
          wrong_cnt_d = '0;
          lock_cnt_d  = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end

      default: begin
        state_d     = S_IDLE;
        wrong_cnt_d = '0;
      end
    endcase

    // Arrival and departure in the same cycle cancel; departures at 0 are dropped
    car_out = gate_if.car_leave && (occ_q != '0);
    occ_d   = occ_q;
    if (car_in && car_out) begin
      occ_d = occ_q;
    end else if (car_in && (occ_q != OCC_W'(CAPACITY))) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (car_out) begin
      occ_d = occ_q - OCC_W'(1);
    end
    full_d = (occ_d == OCC_W'(CAPACITY));

    // Lights decoded from the next state so they align with the state register
    red_d       = (state_d == S_WAIT_PASS) || (state_d == S_WRONG_PASS) ||
                  (state_d == S_TAILGATE)  || (state_d == S_LOCKOUT);
    green_d     = (state_d == S_RIGHT_PASS);
    gate_open_d = (state_d == S_RIGHT_PASS);
    lockout_d   = (state_d == S_LOCKOUT);
  end

  assign gate_if.red       = red_q;
  assign gate_if.green     = green_q;
  assign gate_if.gate_open = gate_open_q;
  assign gate_if.lockout   = lockout_q;
  assign gate_if.full      = full_q;
  assign gate_if.occupancy = occ_q;
  assign gate_if.wrong_cnt = wrong_cnt_q;

endmodule
